// File: rtl/bram_arb2.sv
// Two-requester round-robin arbiter and access sequencer for a single-port BRAM
// with one-cycle registered read data. Read results are steered back to the issuer.
module bram_arb2 #(
    parameter int WIDTH  = 8,
    parameter int ADDR_W = 11
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_a,
    input  logic              we_a,
    input  logic [ADDR_W-1:0] addr_a,
    input  logic [WIDTH-1:0]  wdata_a,
    input  logic              lock_a,
    output logic              gnt_a,
    output logic              rvalid_a,
    output logic [WIDTH-1:0]  rdata_a,
    input  logic              req_b,
    input  logic              we_b,
    input  logic [ADDR_W-1:0] addr_b,
    input  logic [WIDTH-1:0]  wdata_b,
    input  logic              lock_b,
    output logic              gnt_b,
    output logic              rvalid_b,
    output logic [WIDTH-1:0]  rdata_b,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [WIDTH-1:0]  mem_din,
    output logic              mem_we,
    input  logic [WIDTH-1:0]  mem_dout
);

    typedef enum logic [1:0] {
        ARB    = 2'd0,
        LOCK_A = 2'd1,
        LOCK_B = 2'd2
    } state_t;

    state_t              state_r;
    logic                last_r;
    logic                gnt_a_s;
    logic                gnt_b_s;
    logic                xfer_a_s;
    logic                xfer_b_s;
    logic [ADDR_W-1:0]   mem_addr_r;
    logic [WIDTH-1:0]    mem_din_r;
    logic                mem_we_r;
    logic                rd_v1_r;
    logic                rd_b1_r;
    logic                rd_v2_r;
    logic                rd_b2_r;
    logic                rvalid_a_r;
    logic                rvalid_b_r;
    logic [WIDTH-1:0]    rdata_a_r;
    logic [WIDTH-1:0]    rdata_b_r;

    // Grant decode: last_r names the previous winner, so a tie goes to the other side.
    always_comb begin
        gnt_a_s = 1'b0;
        gnt_b_s = 1'b0;
        if (!rst_n) begin
            gnt_a_s = 1'b0;
            gnt_b_s = 1'b0;
        end else begin
            case (state_r)
                ARB: begin
                    if (req_a && req_b) begin
                        gnt_a_s = last_r;
                        gnt_b_s = ~last_r;
                    end else begin
                        gnt_a_s = req_a;
                        gnt_b_s = req_b;
                    end
                end
                LOCK_A:  gnt_a_s = req_a;
                LOCK_B:  gnt_b_s = req_b;
                default: begin
                    gnt_a_s = 1'b0;
                    gnt_b_s = 1'b0;
                end
            endcase
        end
    end

    assign xfer_a_s = req_a & gnt_a_s;
    assign xfer_b_s = req_b & gnt_b_s;
    assign gnt_a    = gnt_a_s;
    assign gnt_b    = gnt_b_s;

    // Ownership state machine and last-served tracking.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r <= ARB;
            last_r  <= 1'b1;
        end else begin
            case (state_r)
                ARB: begin
                    if (xfer_a_s) begin
                        last_r <= 1'b0;
                        if (lock_a) begin
                            state_r <= LOCK_A;
                        end
                    end else if (xfer_b_s) begin
                        last_r <= 1'b1;
                        if (lock_b) begin
                            state_r <= LOCK_B;
                        end
                    end
                end
                LOCK_A: begin
                    if (xfer_a_s) begin
                        last_r <= 1'b0;
                    end
                    if (!lock_a) begin
                        state_r <= ARB;
                    end
                end
                LOCK_B: begin
                    if (xfer_b_s) begin
                        last_r <= 1'b1;
                    end
                    if (!lock_b) begin
                        state_r <= ARB;
                    end
                end
                default: begin
                    state_r <= ARB;
                    last_r  <= 1'b1;
                end
            endcase
        end
    end

    // Issue stage: present the granted access to the BRAM and tag reads with their owner.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            mem_addr_r <= {ADDR_W{1'b0}};
            mem_din_r  <= {WIDTH{1'b0}};
            mem_we_r   <= 1'b0;
            rd_v1_r    <= 1'b0;
            rd_b1_r    <= 1'b0;
        end else if (xfer_a_s) begin
            mem_addr_r <= addr_a;
            mem_din_r  <= wdata_a;
            mem_we_r   <= we_a;
            rd_v1_r    <= ~we_a;
            rd_b1_r    <= 1'b0;
        end else if (xfer_b_s) begin
            mem_addr_r <= addr_b;
            mem_din_r  <= wdata_b;
            mem_we_r   <= we_b;
            rd_v1_r    <= ~we_b;
            rd_b1_r    <= 1'b1;
        end else begin
            mem_we_r   <= 1'b0;
            rd_v1_r    <= 1'b0;
        end
    end

    // Return stage: the tag trails the BRAM output register by one cycle.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rd_v2_r    <= 1'b0;
            rd_b2_r    <= 1'b0;
            rvalid_a_r <= 1'b0;
            rvalid_b_r <= 1'b0;
            rdata_a_r  <= {WIDTH{1'b0}};
            rdata_b_r  <= {WIDTH{1'b0}};
        end else begin
            rd_v2_r    <= rd_v1_r;
            rd_b2_r    <= rd_b1_r;
            rvalid_a_r <= rd_v2_r & ~rd_b2_r;
            rvalid_b_r <= rd_v2_r & rd_b2_r;
            if (rd_v2_r && !rd_b2_r) begin
                rdata_a_r <= mem_dout;
            end
            if (rd_v2_r && rd_b2_r) begin
                rdata_b_r <= mem_dout;
            end
        end
    end

    assign mem_addr = mem_addr_r;
    assign mem_din  = mem_din_r;
    assign mem_we   = mem_we_r;
    assign rvalid_a = rvalid_a_r;
    assign rvalid_b = rvalid_b_r;
    assign rdata_a  = rdata_a_r;
    assign rdata_b  = rdata_b_r;

endmodule
